// File: rtl/ofu_pkg.sv
// Shared types and sizes for the operand fetch unit and its register scoreboard.
package ofu_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One decoded instruction as parked in the hold register.
    typedef struct packed {
        logic [REG_AW-1:0] rdst;
        logic [REG_AW-1:0] rsrc1;
        logic [REG_AW-1:0] rsrc2;
        logic              use1;
        logic              use2;
        logic              wr;
    } instr_t;

    function automatic logic wb_hits(input logic              wb_write,
                                     input logic [REG_AW-1:0] wb_rdst,
                                     input logic [REG_AW-1:0] addr);
        return wb_write && (wb_rdst == addr);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one bit per register, set at issue, cleared at writeback.
module reg_scoreboard
    import ofu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic [REG_AW-1:0] lookup_a_i,
    input  logic [REG_AW-1:0] lookup_b_i,
    input  logic [REG_AW-1:0] lookup_c_i,
    output logic              pend_a_o,
    output logic              pend_b_o,
    output logic              pend_c_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    // Kept apart from the set path: lookups feed the issue decision, which drives set_en_i.
    always_comb begin
        clr_mask = '0;
        if (clr_en_i) begin
            clr_mask[clr_addr_i] = 1'b1;
        end
    end

    // Applying the set after the clear lets a new writer win over a retiring one.
    always_comb begin
        set_mask = '0;
        if (set_en_i) begin
            set_mask[set_addr_i] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A writeback landing this cycle already resolves the register.
    assign pend_a_o = pending_q[lookup_a_i] && !clr_mask[lookup_a_i];
    assign pend_b_o = pending_q[lookup_b_i] && !clr_mask[lookup_b_i];
    assign pend_c_o = pending_q[lookup_c_i] && !clr_mask[lookup_c_i];

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: parks one decoded instruction, stalls on RAW/WAW hazards,
// reads the register file with writeback bypass and registers the operand bundle.
module operand_fetch_unit
    import ofu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rdst,
    input  logic [REG_AW-1:0] in_rsrc1,
    input  logic [REG_AW-1:0] in_rsrc2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic              in_wr,
    output logic [REG_AW-1:0] Rsrc1,
    output logic [REG_AW-1:0] Rsrc2,
    input  logic [DATA_W-1:0] RA,
    input  logic [DATA_W-1:0] RB,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_rdst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb,
    output logic [REG_AW-1:0] out_rdst,
    output logic              out_wr
);

    state_e            state_q, state_d;
    instr_t            hold_q, hold_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [REG_AW-1:0] rdst_q, rdst_d;
    logic              wr_q, wr_d;

    logic pend_src1;
    logic pend_src2;
    logic pend_dst;
    logic hazard;
    logic issue;
    logic in_xfer;
    logic [DATA_W-1:0] opa_sel;
    logic [DATA_W-1:0] opb_sel;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (issue && hold_q.wr),
        .set_addr_i (hold_q.rdst),
        .clr_en_i   (wb_write),
        .clr_addr_i (wb_rdst),
        .lookup_a_i (hold_q.rsrc1),
        .lookup_b_i (hold_q.rsrc2),
        .lookup_c_i (hold_q.rdst),
        .pend_a_o   (pend_src1),
        .pend_b_o   (pend_src2),
        .pend_c_o   (pend_dst)
    );

    assign hazard   = (hold_q.use1 && pend_src1) ||
                      (hold_q.use2 && pend_src2) ||
                      (hold_q.wr   && pend_dst);
    assign issue    = (state_q == HOLD) && !hazard && (!valid_q || out_ready);
    assign in_ready = (state_q == IDLE) || issue;
    assign in_xfer  = in_valid && in_ready;

    assign Rsrc1 = (state_q == HOLD) ? hold_q.rsrc1 : '0;
    assign Rsrc2 = (state_q == HOLD) ? hold_q.rsrc2 : '0;

    // Unused sources take the raw register-file data; used ones see the in-flight writeback.
    assign opa_sel = (hold_q.use1 && wb_hits(wb_write, wb_rdst, Rsrc1)) ? wb_data : RA;
    assign opb_sel = (hold_q.use2 && wb_hits(wb_write, wb_rdst, Rsrc2)) ? wb_data : RB;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (issue && !in_xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (in_xfer) begin
            hold_d.rdst  = in_rdst;
            hold_d.rsrc1 = in_rsrc1;
            hold_d.rsrc2 = in_rsrc2;
            hold_d.use1  = in_use1;
            hold_d.use2  = in_use2;
            hold_d.wr    = in_wr;
        end
    end

    always_comb begin
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rdst_d  = rdst_q;
        wr_d    = wr_q;
        if (issue) begin
            valid_d = 1'b1;
            opa_d   = opa_sel;
            opb_d   = opb_sel;
            rdst_d  = hold_q.rdst;
            wr_d    = hold_q.wr;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rdst_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rdst_q  <= rdst_d;
            wr_q    <= wr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_opa   = opa_q;
    assign out_opb   = opb_q;
    assign out_rdst  = rdst_q;
    assign out_wr    = wr_q;

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 in_valid  in  1  decoded instruction present.
REQ-004 in_ready  out  1  unit accepts instruction this cycle.
REQ-005 in_rdst / in_rsrc1 / in_rsrc2  in  5 each  destination / source register addresses.
REQ-006 in_use1 / in_use2 / in_wr  in  1 each  source 1 used / source 2 used / writes destination.
REQ-007 Rsrc1 / Rsrc2  out  5 each  read addresses driven to the register file.
REQ-008 RA / RB  in  32 each  combinational read data returned by the register file.
REQ-009 wb_write / wb_rdst / wb_data  in  1 / 5 / 32  writeback port, the same signals that drive RF_WRITE / Rdst / RY.
REQ-010 out_valid  out  1  operand bundle valid.
REQ-011 out_ready  in  1  downstream accepts the bundle.
REQ-012 out_opa / out_opb  out  32 each  resolved operands.
REQ-013 out_rdst / out_wr  out  5 / 1  forwarded destination and write flag.

Function
REQ-014 Handshake: transfer occurs when valid && ready on both ports; held outputs stay stable while out_valid && !out_ready.
REQ-015 FSM states: IDLE (hold register empty) and HOLD (hold register holds one instruction).
REQ-016 IDLE -> HOLD on input transfer; HOLD -> IDLE on issue without a same-cycle input transfer; HOLD -> HOLD on issue with a same-cycle input transfer, or while stalled.
REQ-017 Rsrc1 / Rsrc2 = hold-register sources in HOLD; 0 in IDLE.
REQ-018 Scoreboard: 32 pending bits; bit r set when an instruction with in_wr=1 and rdst=r issues; cleared when wb_write=1 and wb_rdst=r.
REQ-019 Register 0 is an ordinary register with no hardwired-zero exception.
REQ-020 Effective pending(r) = pending[r] && !(wb_write && wb_rdst==r).
REQ-021 Hazard = (in_use1 && pending(rsrc1)) || (in_use2 && pending(rsrc2)) || (in_wr && pending(rdst)); RAW and WAW both stall.
REQ-022 Issue occurs when state=HOLD && !hazard && (!out_valid || out_ready); on that edge operands, rdst and wr load into the output register and out_valid is set.
REQ-023 Bypass: if wb_write && wb_rdst==Rsrc1 then out_opa captures wb_data, else RA; same rule for out_opb with Rsrc2 / RB.
REQ-024 Unused sources (in_useX=0) capture RA/RB unchanged and never stall.
REQ-025 Same-cycle set and clear of the same scoreboard bit: set wins.
REQ-026 out_valid clears on an out_ready transfer unless an issue occurs on the same edge.
REQ-027 in_ready = (state==IDLE) || issue (combinational); sustained throughput is 1 instruction/cycle.
REQ-028 Latency: instruction accepted at edge k, no hazard, output free -> out_valid high after edge k+1.
REQ-029 A wb_write to a non-pending register only updates the register file and leaves the scoreboard unchanged.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, all pending bits 0, out_valid=0, out_opa=out_opb=0, out_rdst=0, out_wr=0, and the hold register to 0.
REQ-031 Reset asserted mid-stall discards the held instruction and the output bundle; wb_write inputs are ignored while rst_n is low.
REQ-032 First input transfer occurs no earlier than the first posedge after rst_n deasserts.

Structure
REQ-033 Shared package ofu_pkg holds REG_AW=5, DATA_W=32, NUM_REGS=32 and the state enum {IDLE, HOLD}.
REQ-034 Sub-module reg_scoreboard contains the pending vector, set/clear logic and the three combinational pending lookups; the top-level module contains the FSM, the bypass muxes and the output register.

Verification
REQ-035 Idle issue: pending=0, instruction rsrc1=3, rsrc2=4, RA=0x11, RB=0x22 -> out_valid one cycle later, opa=0x11, opb=0x22.
REQ-036 RAW stall: issue wr r5, then read r5 -> in_ready=0 and no issue until wb_write r5 with 0xDEAD; in that same cycle the instruction issues with opa=0xDEAD via bypass.
REQ-037 WAW stall: two back-to-back writes to r7 -> the second holds until wb r7 occurs, and pending[7] stays 1 afterwards because set wins.
REQ-038 Backpressure: out_ready=0 for 3 cycles -> output stable, second instruction held, in_ready=0; on release, 1/cycle flow resumes.
REQ-039 Reset during a HOLD stall with pending[9]=1 -> out_valid=0, pending=0, state IDLE immediately and without a clock edge.
REQ-040 Unused source: in_use2=0, rsrc2=5 pending -> no stall, opb=RB.
